// File: rtl/gng_arbiter_if.sv
// Bus between the arbiter and its environment: requesters, gng handshake, returned samples.
interface gng_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GAP_W   = 4
);
    logic [NUM_REQ-1:0] req;
    logic [GAP_W-1:0]   gap;
    logic [NUM_REQ-1:0] grant;
    logic               gng_ce;
    logic               gng_valid;
    logic [15:0]        gng_data;
    logic [NUM_REQ-1:0] out_valid;
    logic [15:0]        out_data;
    logic               busy;
    logic               err;

    modport master (
        input  req, gap, gng_valid, gng_data,
        output grant, gng_ce, out_valid, out_data, busy, err
    );

    modport slave (
        output req, gap, gng_valid, gng_data,
        input  grant, gng_ce, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/gng_arbiter.sv
// Round-robin sharing of one Gaussian noise generator: ce issue with minimum gap,
// in-order tag FIFO routing each returned sample back to its requester.
module gng_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned GAP_W     = 4
) (
    input  logic          clk,
    input  logic          rstn,
    gng_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_out_valid;
    logic               r_gng_ce;
    logic               r_busy;
    logic               r_err;
    logic [15:0]        r_out_data;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic               w_issue;
    logic               w_pop;
    logic               w_drop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [IDX_W-1:0]   w_head;

    // A requester granted this cycle is masked so a held level cannot double-issue.
    assign w_eligible = bus.req & ~r_grant;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin : winner_search
        int unsigned k;
        k        = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(r_rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!w_found && w_eligible[IDX_W'(k)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(k);
            end
        end
    end

    assign w_issue     = w_found && (r_count < CNT_W'(TAG_DEPTH)) && (r_gap_cnt == '0);
    assign w_pop       = bus.gng_valid && (r_count != '0);
    assign w_drop      = bus.gng_valid && (r_count == '0);
    assign w_count_nxt = r_count + CNT_W'(w_issue) - CNT_W'(w_pop);
    assign w_head      = r_tag_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_grant     <= '0;
            r_out_valid <= '0;
            r_gng_ce    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_gap_cnt   <= '0;
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                r_tag_mem[i] <= '0;
            end
        end else begin
            r_gng_ce <= w_issue;
            r_grant  <= w_issue ? (NUM_REQ'(1) << w_winner) : '0;

            if (w_issue) begin
                r_tag_mem[r_wr_ptr] <= w_winner;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
                r_rr_ptr            <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0
                                                                         : w_winner + IDX_W'(1);
                r_gap_cnt           <= bus.gap;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            // gng returns in issue order, so the FIFO head owns the sample.
            r_out_valid <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_out_data <= bus.gng_data;
            end

            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt != '0) || w_issue;
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.gng_ce    = r_gng_ce;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_gng_arbiter.sv
// Bench for gng_arbiter: two instances (depth 8 / latency 3, depth 2 / latency 5) with gng stubs.
module tb_gng_arbiter;
    logic clk = 1'b0;
    logic rstn;
    logic force_v;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    gng_arbiter_if #(.NUM_REQ(4), .GAP_W(4)) b0 ();
    gng_arbiter_if #(.NUM_REQ(4), .GAP_W(4)) b1 ();

    gng_arbiter #(.NUM_REQ(4), .TAG_DEPTH(8), .GAP_W(4)) dut0 (.clk(clk), .rstn(rstn), .bus(b0));
    gng_arbiter #(.NUM_REQ(4), .TAG_DEPTH(2), .GAP_W(4)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));

    // gng stubs: fixed-latency valid, data counts 1,2,3,... per returned sample
    logic [7:0]  pipe0, pipe1;
    logic [15:0] sdat0, sdat1;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe0 <= '0; pipe1 <= '0; sdat0 <= '0; sdat1 <= '0;
        end else begin
            pipe0 <= {pipe0[6:0], b0.gng_ce};
            pipe1 <= {pipe1[6:0], b1.gng_ce};
            if (pipe0[1]) sdat0 <= sdat0 + 16'd1;
            if (pipe1[3]) sdat1 <= sdat1 + 16'd1;
        end
    end
    assign b0.gng_valid = pipe0[2] | force_v;
    assign b0.gng_data  = sdat0;
    assign b1.gng_valid = pipe1[4];
    assign b1.gng_data  = sdat1;

    // Reference model: list of outstanding owners, rotating priority in plain integer arithmetic
    logic [3:0]  m_grant [2];
    logic [3:0]  m_ov    [2];
    logic        m_ce    [2];
    logic        m_busy  [2];
    logic        m_err   [2];
    logic [15:0] m_od    [2];
    int          m_rr    [2];
    int          m_gapc  [2];
    int          m_tags  [2][16];
    int          m_n     [2];
    logic [3:0]  md_req, md_el, md_gap;
    logic        md_v;
    logic [15:0] md_d;
    int          md_win, md_dep;
    logic        md_full;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int u = 0; u < 2; u++) begin
                m_grant[u] = '0; m_ov[u] = '0; m_ce[u] = 1'b0; m_busy[u] = 1'b0;
                m_err[u] = 1'b0; m_od[u] = '0; m_rr[u] = 0; m_gapc[u] = 0; m_n[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                md_req = (u == 0) ? b0.req : b1.req;
                md_gap = (u == 0) ? b0.gap : b1.gap;
                md_v   = (u == 0) ? b0.gng_valid : b1.gng_valid;
                md_d   = (u == 0) ? b0.gng_data : b1.gng_data;
                md_dep = (u == 0) ? 8 : 2;
                md_el  = md_req & ~m_grant[u];
                md_win = -1;
                for (int k = 0; k < 4; k++) begin
                    if (md_win < 0 && md_el[(m_rr[u] + k) % 4]) md_win = (m_rr[u] + k) % 4;
                end
                md_full = (m_n[u] >= md_dep);
                m_ov[u] = '0;
                if (md_v) begin
                    if (m_n[u] > 0) begin
                        m_ov[u] = 4'(1 << m_tags[u][0]);
                        m_od[u] = md_d;
                        for (int j = 0; j < 15; j++) m_tags[u][j] = m_tags[u][j+1];
                        m_n[u] = m_n[u] - 1;
                    end else begin
                        m_err[u] = 1'b1;
                    end
                end
                if (md_win >= 0 && !md_full && m_gapc[u] == 0) begin
                    m_tags[u][m_n[u]] = md_win;
                    m_n[u]     = m_n[u] + 1;
                    m_rr[u]    = (md_win + 1) % 4;
                    m_gapc[u]  = int'(md_gap);
                    m_grant[u] = 4'(1 << md_win);
                    m_ce[u]    = 1'b1;
                end else begin
                    if (m_gapc[u] > 0) m_gapc[u] = m_gapc[u] - 1;
                    m_grant[u] = '0;
                    m_ce[u]    = 1'b0;
                end
                m_busy[u] = (m_n[u] > 0) || m_ce[u];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, comparing both instances against the model mid-cycle
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            chk("grant0",  32'(b0.grant),     32'(m_grant[0]));
            chk("ce0",     32'(b0.gng_ce),    32'(m_ce[0]));
            chk("ovalid0", 32'(b0.out_valid), 32'(m_ov[0]));
            chk("odata0",  32'(b0.out_data),  32'(m_od[0]));
            chk("busy0",   32'(b0.busy),      32'(m_busy[0]));
            chk("err0",    32'(b0.err),       32'(m_err[0]));
            chk("grant1",  32'(b1.grant),     32'(m_grant[1]));
            chk("ce1",     32'(b1.gng_ce),    32'(m_ce[1]));
            chk("ovalid1", 32'(b1.out_valid), 32'(m_ov[1]));
            chk("odata1",  32'(b1.out_data),  32'(m_od[1]));
            chk("busy1",   32'(b1.busy),      32'(m_busy[1]));
            chk("err1",    32'(b1.err),       32'(m_err[1]));
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
    endtask

    int last, prevd;

    initial begin
        rstn = 1'b0; force_v = 1'b0;
        b0.req = '0; b0.gap = '0; b1.req = '0; b1.gap = '0;
        step(2);
        chk("rst_grant", 32'(b0.grant), 0);
        chk("rst_ce",    32'(b0.gng_ce), 0);
        chk("rst_busy",  32'(b0.busy), 0);
        chk("rst_err",   32'(b0.err), 0);
        rstn = 1'b1;
        step(1);

        // single request, gap 0
        b0.req = 4'b0001;
        step(1);
        chk("single_grant", 32'(b0.grant), 32'h1);
        chk("single_ce",    32'(b0.gng_ce), 1);
        b0.req = '0;
        step(4);
        chk("single_ov",   32'(b0.out_valid), 32'h1);
        chk("single_data", 32'(b0.out_data), 1);
        step(1);
        chk("single_busy", 32'(b0.busy), 0);
        chk("single_err",  32'(b0.err), 0);

        // all four held, gap 0
        do_reset();
        b0.req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("rr_ce",    32'(b0.gng_ce), 1);
            chk("rr_grant", 32'(b0.grant), 32'(1 << (i % 4)));
            if (i >= 4) begin
                chk("rr_ov",   32'(b0.out_valid), 32'(1 << ((i - 4) % 4)));
                chk("rr_data", 32'(b0.out_data), 32'(i - 3));
            end
        end
        b0.req = '0;
        step(8);
        chk("rr_drain_busy", 32'(b0.busy), 0);
        chk("rr_err",        32'(b0.err), 0);

        // gap 7 gives 1-in-8 ce spacing
        do_reset();
        b0.req = 4'b0001; b0.gap = 4'd7;
        last = -1; prevd = -1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (b0.gng_ce) begin
                if (last >= 0) chk("gap7_spacing", 32'(cyc - last), 8);
                last = cyc;
            end
            if (b0.out_valid != '0) begin
                if (prevd >= 0) chk("gap7_data", 32'(b0.out_data), 32'(prevd + 1));
                prevd = int'(b0.out_data);
            end
        end
        b0.req = '0; b0.gap = '0;
        step(12);

        // depth-2 instance stalls when full, resumes after a pop
        do_reset();
        b1.req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i < 9) chk("full_ce", 32'(b1.gng_ce), 32'(i == 0 || i == 1 || i == 7 || i == 8));
            chk("full_busy", 32'(b1.busy), 1);
            chk("full_err",  32'(b1.err), 0);
        end
        b1.req = '0;
        step(12);

        // valid with empty FIFO sets sticky err
        do_reset();
        step(2);
        force_v = 1'b1;
        step(1);
        force_v = 1'b0;
        chk("drop_err", 32'(b0.err), 1);
        chk("drop_ov",  32'(b0.out_valid), 0);
        b0.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("drop_sticky", 32'(b0.err), 1);
        end
        b0.req = '0;
        step(8);
        do_reset();
        chk("drop_cleared", 32'(b0.err), 0);

        // reset mid-burst with three tags outstanding
        step(1);
        b0.req = 4'b1111;
        step(3);
        rstn = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(b0.grant), 0);
        chk("mid_rst_ce",    32'(b0.gng_ce), 0);
        chk("mid_rst_ov",    32'(b0.out_valid), 0);
        chk("mid_rst_data",  32'(b0.out_data), 0);
        chk("mid_rst_busy",  32'(b0.busy), 0);
        step(2);
        rstn = 1'b1;
        step(1);
        chk("post_rst_grant", 32'(b0.grant), 32'h1);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("post_rst_no_ov", 32'(b0.out_valid), 0);
        end
        step(1);
        chk("post_rst_ov",   32'(b0.out_valid), 32'h1);
        chk("post_rst_data", 32'(b0.out_data), 1);
        b0.req = '0;
        step(8);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            b0.req  = 4'($urandom);
            b1.req  = 4'($urandom);
            if ($urandom_range(0, 31) == 0) b0.gap = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) b1.gap = 4'($urandom_range(0, 2));
            force_v = ($urandom_range(0, 63) == 0);
            if (i == 200) begin
                force_v = 1'b0;
                do_reset();
            end
            step(1);
        end
        force_v = 1'b0;
        b0.req = '0; b1.req = '0;
        step(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gng_arbiter.md
Name: gng_arbiter

Overview:
- Shares one Gaussian noise generator instance (gng: clk, rstn, ce, valid_out, data_out[15:0]) among NUM_REQ consumers.
- Round-robin arbitrates sample requests and drives the generator's ce.
- Enforces a programmable minimum gap between ce pulses.
- Tracks in-flight samples in a tag FIFO and routes each returned sample to the requester that was granted it.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TAG_DEPTH, 8, maximum outstanding ce pulses not yet answered by valid_out; power of 2, at least the generator latency.
- GAP_W, 4, width of the gap configuration input.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock, asynchronous, active-low. Also drives the gng instance.
- req  in  NUM_REQ  per-requester sample request, level-sensitive.
- gap  in  GAP_W  minimum idle cycles between consecutive ce pulses; quasi-static.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: a sample was issued for requester i.
- gng_ce  out  1  to gng ce; one-cycle pulse per sample.
- gng_valid  in  1  from gng valid_out.
- gng_data  in  16  from gng data_out (signed).
- out_valid  out  NUM_REQ  one-hot, one-cycle pulse: out_data belongs to requester i.
- out_data  out  16  returned sample, registered.
- busy  out  1  high when tag count is nonzero or gng_ce is high.
- err  out  1  sticky: gng_valid arrived with tag FIFO empty.

Behaviour:
- Reset values: grant=0, gng_ce=0, out_valid=0, out_data=0, err=0, busy=0, rr pointer=0, tag FIFO empty, gap counter=0.
- Eligible set = req & ~grant. A requester whose grant is high this cycle is masked, so one held req cannot double-issue from a stale level.
- Issue condition, evaluated each cycle: eligible != 0 AND tag count < TAG_DEPTH AND gap counter == 0.
- Winner: first eligible index at or above rr pointer, wrapping modulo NUM_REQ.
- On issue at edge t, during cycle t+1:
  - gng_ce=1 and grant[winner]=1, both registered.
  - Winner index pushed into the tag FIFO.
  - rr pointer becomes (winner+1) mod NUM_REQ.
  - gap counter loaded with gap.
- Gap counter decrements each cycle while nonzero. gap=0 allows a ce every cycle. gap=g gives ce spacing of g+1 cycles.
- Return path: when gng_valid is sampled high with FIFO non-empty, the head tag is popped. Next cycle, out_valid[tag]=1 and out_data=gng_data. Latency is 1 cycle from gng_valid.
- Simultaneous push and pop in the same cycle: count unchanged; ordering preserved. The gng is in-order, so FIFO order equals return order.
- Full (count == TAG_DEPTH): no issue. Requests stay pending and no grant is given; resume the cycle after a pop frees a slot.
- gng_valid with FIFO empty: sample dropped, no out_valid, err set. err clears only on rstn.
- Tag FIFO: depth TAG_DEPTH, width clog2(NUM_REQ). Pointers wrap modulo TAG_DEPTH. Count width is clog2(TAG_DEPTH)+1.
- Requesters wanting exactly one sample deassert req in the cycle their grant is high. A req that stays high after its grant is re-eligible on the next cycle.
- Reset mid-operation: every register clears immediately (asynchronous). In-flight tags are discarded; the gng shares rstn, so its pipeline is also flushed. After release, arbitration restarts from index 0.
- gap changed mid-count takes effect on the next load only.

Test Plan:
Bench uses a gng stub with fixed latency 3 (gng_valid 3 cycles after gng_ce), returning data 1, 2, 3, ... in order.
- req=0001 for one cycle, gap=0: one gng_ce and grant[0] pulse, 1 cycle after req. out_valid[0]=1 with out_data=1, exactly 1 cycle after gng_valid. err=0, busy returns to 0.
- req=1111 held, gap=0:
  - gng_ce high every cycle.
  - Grants follow 0,1,2,3,0,...
  - out_valid follows the same sequence with data 1,2,3,4,5.
  - No drops.
- req=0001 held, gap=7: gng_ce pulses exactly 8 cycles apart (1-in-8 duty), data increments by 1 per pulse.
- TAG_DEPTH=2, stub latency 5, req=0011 held, gap=0:
  - Exactly 2 ce pulses, then stall until the first gng_valid.
  - Issue resumes the cycle after the pop.
  - busy stays 1 and err stays 0 throughout.
- Force gng_valid=1 with FIFO empty: err=1, no out_valid. err stays 1 through later traffic until rstn pulse.
- req=1111 held, rstn pulsed low mid-burst with 3 tags outstanding:
  - All outputs are 0 during reset.
  - After release, first grant is grant[0].
  - No out_valid for the discarded tags.
